// File: rtl/signal_demodulation.sv
// rtl/signal_demodulation.sv - ASK/FSK/PSK symbol demodulator for offset-binary ADC samples
// Define DEMOD_METRIC_EN to add the dbg_metric and sym_count outputs.
module signal_demodulation #(
    parameter int SYM_LEN = 256,
    parameter int ASK_THR = 8192,
    parameter int FSK_THR = 3,
    parameter int HYST    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  key,
    input  logic        sym_sync,
    input  logic [7:0]  adc_data,
    output logic        adc_clk,
    output logic        bit_out,
    output logic        bit_valid,
`ifdef DEMOD_METRIC_EN
    output logic [17:0] dbg_metric,
    output logic [15:0] sym_count,
`endif
    output logic        busy
);
    localparam int CW = $clog2(SYM_LEN);
    localparam logic [2:0] KEY_ASK = 3'b110;
    localparam logic [2:0] KEY_FSK = 3'b101;
    localparam logic [2:0] KEY_PSK = 3'b011;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(SYM_LEN - 1);
    localparam logic [17:0]       ASK_THR_V = 18'(ASK_THR);
    localparam logic [5:0]        FSK_THR_V = 6'(FSK_THR);
    localparam logic signed [8:0] HYST_P    = 9'(HYST);
    localparam logic signed [8:0] HYST_N    = -HYST_P;

    typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         adc_q, adc_d;
    logic [2:0]         key_q, key_d, mode_q, mode_d;
    logic               sync_q, sync_d, sign_q, sign_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [17:0]        acc_a_q, acc_a_d;
    logic [5:0]         nz_q, nz_d;
    logic signed [17:0] acc_p_q, acc_p_d;
    logic               bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
`ifdef DEMOD_METRIC_EN
    logic [17:0]        dbg_q, dbg_d;
    logic [15:0]        sym_cnt_q, sym_cnt_d;
`endif

    logic signed [8:0]  s;
    logic [8:0]         abs_s;
    logic signed [17:0] s_ext, psk_term;
    logic               flip, accumulate, restart, decide, clear, dec_bit, key_valid;
    logic [CW-1:0]      cur_cnt;
    logic [17:0]        base_a;
    logic [5:0]         base_nz;
    logic signed [17:0] base_p;

    always_comb begin
        adc_d  = adc_data;
        key_d  = key;
        sync_d = sym_sync;

        s     = $signed({1'b0, adc_q}) - 9'sd128;
        abs_s = s[8] ? -s : s;
        s_ext = {{9{s[8]}}, s};

        // Hysteretic sign tracker; its state deliberately survives symbol boundaries.
        sign_d = sign_q;
        flip   = 1'b0;
        if (!sign_q && (s >= HYST_P)) begin
            sign_d = 1'b1;
            flip   = 1'b1;
        end else if (sign_q && (s <= HYST_N)) begin
            sign_d = 1'b0;
            flip   = 1'b1;
        end

        key_valid = (key_q == KEY_ASK) || (key_q == KEY_FSK) || (key_q == KEY_PSK);

        case (mode_q)
            KEY_ASK: dec_bit = acc_a_q > ASK_THR_V;
            KEY_FSK: dec_bit = nz_q >= FSK_THR_V;
            KEY_PSK: dec_bit = !acc_p_q[17];
            default: dec_bit = 1'b0;
        endcase

        state_d    = state_q;
        mode_d     = mode_q;
        accumulate = 1'b0;
        restart    = 1'b0;
        decide     = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    mode_d     = key_q;
                    accumulate = 1'b1;
                    restart    = 1'b1;
                end
            end
            default: begin
                if (key_q != mode_q) begin
                    decide = (state_q == DUMP);
                    if (key_valid) begin
                        mode_d     = key_q;
                        accumulate = 1'b1;
                        restart    = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end else if ((state_q == DUMP) || (sync_q && (cnt_q == CNT_LAST))) begin
                    decide     = 1'b1;
                    accumulate = 1'b1;
                    restart    = 1'b1;
                end else begin
                    accumulate = 1'b1;
                    restart    = sync_q;
                end
            end
        endcase

        // A restart makes the current sample cnt 0 of a fresh symbol.
        cur_cnt  = restart ? '0 : cnt_q;
        base_a   = restart ? '0 : acc_a_q;
        base_nz  = restart ? '0 : nz_q;
        base_p   = restart ? '0 : acc_p_q;
        psk_term = cur_cnt[CW-1] ? -s_ext : s_ext;

        cnt_d   = cnt_q;
        acc_a_d = acc_a_q;
        nz_d    = nz_q;
        acc_p_d = acc_p_q;
        if (clear) begin
            cnt_d   = '0;
            acc_a_d = '0;
            nz_d    = '0;
            acc_p_d = '0;
        end else if (accumulate) begin
            cnt_d   = cur_cnt + 1'b1;
            acc_a_d = base_a + {9'd0, abs_s};
            nz_d    = (flip && (base_nz != 6'h3f)) ? base_nz + 6'd1 : base_nz;
            acc_p_d = base_p + psk_term;
            state_d = (cur_cnt == CNT_LAST) ? DUMP : RUN;
        end

        bit_valid_d = decide;
        bit_out_d   = decide ? dec_bit : bit_out_q;
`ifdef DEMOD_METRIC_EN
        dbg_d     = dbg_q;
        sym_cnt_d = sym_cnt_q;
        if (decide) begin
            sym_cnt_d = sym_cnt_q + 16'd1;
            case (mode_q)
                KEY_ASK: dbg_d = acc_a_q;
                KEY_FSK: dbg_d = {12'd0, nz_q};
                KEY_PSK: dbg_d = acc_p_q;
                default: dbg_d = '0;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            adc_q       <= '0;
            key_q       <= '0;
            mode_q      <= '0;
            sync_q      <= 1'b0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            acc_a_q     <= '0;
            nz_q        <= '0;
            acc_p_q     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
`ifdef DEMOD_METRIC_EN
            dbg_q       <= '0;
            sym_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            adc_q       <= adc_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            sync_q      <= sync_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            acc_a_q     <= acc_a_d;
            nz_q        <= nz_d;
            acc_p_q     <= acc_p_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
`ifdef DEMOD_METRIC_EN
            dbg_q       <= dbg_d;
            sym_cnt_q   <= sym_cnt_d;
`endif
        end
    end

    assign adc_clk   = ~clk;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = (state_q != IDLE);
`ifdef DEMOD_METRIC_EN
    assign dbg_metric = dbg_q;
    assign sym_count  = sym_cnt_q;
`endif
endmodule

// File: tb/tb_signal_demodulation.sv
// tb/tb_signal_demodulation.sv - directed bench for signal_demodulation (ASK/FSK/PSK, sync/key/reset edges)
module tb_signal_demodulation;
    logic        clk = 1'b0;
    logic        rst_n, sym_sync;
    logic [2:0]  key;
    logic [7:0]  adc_data;
    logic        adc_clk, bit_out, bit_valid, busy;
`ifdef DEMOD_METRIC_EN
    logic [17:0] dbg_metric;
    logic [15:0] sym_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int st_cyc[$];
    int st_bit[$];
    int st_dbg[$];

    signal_demodulation dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .sym_sync  (sym_sync),
        .adc_data  (adc_data),
        .adc_clk   (adc_clk),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
`ifdef DEMOD_METRIC_EN
        .dbg_metric(dbg_metric),
        .sym_count (sym_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bit_valid) begin
            st_cyc.push_back(cyc);
            st_bit.push_back(int'(bit_out));
`ifdef DEMOD_METRIC_EN
            st_dbg.push_back(int'(dbg_metric));
`else
            st_dbg.push_back(0);
`endif
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sine(input int idx, input int per);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * $itor(idx) / $itor(per));
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic int rel(input int i);
        if (i < st_cyc.size()) return st_cyc[i] - t0 - 1;
        return -1;
    endfunction

    function automatic int sbit(input int i);
        if (i < st_bit.size()) return st_bit[i];
        return -1;
    endfunction

    function automatic int sdbg(input int i);
        if (i < st_dbg.size()) return st_dbg[i];
        return -1;
    endfunction

    task automatic step(input bit sync, input int d);
        sym_sync = sync;
        adc_data = 8'(d);
        @(posedge clk);
        #1;
        sym_sync = 1'b0;
    endtask

    task automatic clear_log();
        st_cyc.delete();
        st_bit.delete();
        st_dbg.delete();
    endtask

    task automatic do_reset(input logic [2:0] k);
        rst_n = 1'b0;
        key = 3'b000;
        sym_sync = 1'b0;
        adc_data = 8'd128;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        key = k;
        repeat (4) step(0, 128);
        clear_log();
    endtask

    initial begin
        int exp_a;
        rst_n = 1'b0;
        key = 3'b000;
        sym_sync = 1'b0;
        adc_data = 8'd128;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("adc_clk_inv", int'(adc_clk), 0);
`ifdef DEMOD_METRIC_EN
        check("rst_dbg", int'(dbg_metric), 0);
        check("rst_sym_count", int'(sym_count), 0);
`endif
        rst_n = 1'b1;

        // ASK: full-scale sine symbol then a silent symbol
        key = 3'b110;
        repeat (4) step(0, 128);
        clear_log();
        t0 = cyc;
        exp_a = 0;
        for (int n = 0; n < 256; n++) begin
            step(n == 0, 128 + sine(n, 256));
            exp_a += (sine(n, 256) < 0) ? -sine(n, 256) : sine(n, 256);
        end
        for (int n = 0; n < 260; n++) step(0, 128);
        check("ask_busy", int'(busy), 1);
        check("ask_strobes", st_cyc.size(), 2);
        check("ask_lat0", rel(0), 257);
        check("ask_bit0", sbit(0), 1);
        check("ask_lat1", rel(1), 513);
        check("ask_bit1", sbit(1), 0);
`ifdef DEMOD_METRIC_EN
        check("ask_dbg0", sdbg(0), exp_a);
        check("ask_dbg1", sdbg(1), 0);
        check("ask_sym_count", int'(sym_count), 2);
`endif

        // FSK: one carrier cycle (2 crossings) then two cycles (4 crossings)
        do_reset(3'b101);
        t0 = cyc;
        for (int n = 0; n < 256; n++) step(n == 0, 128 + sine(n, 256));
        for (int n = 0; n < 256; n++) step(0, 128 + sine(2 * n, 256));
        for (int n = 0; n < 4; n++) step(0, 128);
        check("fsk_strobes", st_cyc.size(), 2);
        check("fsk_lat0", rel(0), 257);
        check("fsk_bit0", sbit(0), 0);
        check("fsk_lat1", rel(1), 513);
        check("fsk_bit1", sbit(1), 1);
`ifdef DEMOD_METRIC_EN
        check("fsk_nz0", sdbg(0), 2);
        check("fsk_nz1", sdbg(1), 4);
`endif

        // PSK: phase 0 then phase 180 (start index 127)
        do_reset(3'b011);
        t0 = cyc;
        for (int n = 0; n < 256; n++) step(n == 0, 128 + sine(n, 256));
        for (int n = 0; n < 256; n++) step(0, 128 + sine(n + 127, 256));
        for (int n = 0; n < 4; n++) step(0, 128);
        check("psk_strobes", st_cyc.size(), 2);
        check("psk_bit0", sbit(0), 1);
        check("psk_bit1", sbit(1), 0);
`ifdef DEMOD_METRIC_EN
        check("psk_sign0", (sdbg(0) >> 17) & 1, 0);
        check("psk_sign1", (sdbg(1) >> 17) & 1, 1);
`endif

        // Resync at cnt 100 discards the partial symbol
        do_reset(3'b110);
        step(1, 255);
        repeat (99) step(0, 255);
        t0 = cyc;
        step(1, 255);
        repeat (299) step(0, 255);
        check("resync_strobes", st_cyc.size(), 1);
        check("resync_lat", rel(0), 257);
        check("resync_bit", sbit(0), 1);

        // Key to an idle code mid-symbol, then back
        do_reset(3'b101);
        step(1, 128);
        repeat (49) step(0, 128);
        key = 3'b111;
        repeat (3) step(0, 128);
        check("key_idle_busy", int'(busy), 0);
        repeat (300) step(0, 128);
        check("key_idle_strobes", st_cyc.size(), 0);
        key = 3'b101;
        t0 = cyc;
        repeat (260) step(0, 128);
        check("key_back_busy", int'(busy), 1);
        check("key_back_strobes", st_cyc.size(), 1);
        check("key_back_lat", rel(0), 257);
        check("key_back_bit", sbit(0), 0);

        // Reset at cnt 200 of the second symbol
        do_reset(3'b110);
        step(1, 255);
        repeat (455) step(0, 255);
        check("pre_rst_strobes", st_cyc.size(), 1);
        check("pre_rst_bit_out", int'(bit_out), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bit_out", int'(bit_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_bit_valid", int'(bit_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        t0 = cyc;
        repeat (256) step(0, 255);
        check("post_rst_early", st_cyc.size(), 0);
        repeat (4) step(0, 255);
        check("post_rst_strobes", st_cyc.size(), 1);
        check("post_rst_lat", rel(0), 257);
        check("post_rst_bit", sbit(0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
